// File: rtl/uart_tx_arbiter.sv
// Two-requester 8N1 UART transmitter with round-robin arbitration and owner lock.
// Define UART_TX_ARB_FIXED_PRIO_EN to make requester 0 win every simultaneous request.
module uart_tx_arbiter #(
   parameter int BAUD_PER = 10416
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_lock,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_lock,
   output logic       req1_ready,
   output logic       tx,
   output logic       busy,
   output logic [1:0] grant
);

   // state | meaning
   // IDLE  | line high, arbitrating, accepts at most one byte per cycle
   // START | start bit (low) for BAUD_PER cycles
   // DATA  | eight data bits, LSB first, BAUD_PER cycles each
   // STOP  | stop bit (high) for BAUD_PER cycles, then back to IDLE
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [13:0] BAUD_LAST = 14'(BAUD_PER - 1);

   state_t      state_q, state_d;
   logic [13:0] baud_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        tx_q;
   logic [1:0]  grant_q;
   logic        lock_q;
   logic        pick0, pick1;
   logic        owner_locked;
   logic        baud_wrap;

   assign baud_wrap = (baud_q == BAUD_LAST);

   always_comb begin
      pick0        = 1'b0;
      pick1        = 1'b0;
      owner_locked = lock_q && ((grant_q[0] && req0_lock) || (grant_q[1] && req1_lock));
      if (state_q == IDLE && !rst) begin
         if (owner_locked) begin
            // a locked owner keeps the line even while it has nothing to send
            pick0 = grant_q[0] && req0_valid;
            pick1 = grant_q[1] && req1_valid;
         end else if (req0_valid && req1_valid) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
            pick0 = 1'b1;
`else
            pick1 = grant_q[0];
            pick0 = !grant_q[0];
`endif
         end else begin
            pick0 = req0_valid;
            pick1 = req1_valid;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick0 || pick1) state_d = START;
         START:   if (baud_wrap) state_d = DATA;
         DATA:    if (baud_wrap && bit_q == 3'd7) state_d = STOP;
         STOP:    if (baud_wrap) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         grant_q <= 2'b00;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            baud_q <= '0;
            bit_q  <= '0;
            if (pick0 || pick1) begin
               tx_q    <= 1'b0;
               shift_q <= pick1 ? req1_data : req0_data;
               grant_q <= {pick1, pick0};
               lock_q  <= pick1 ? req1_lock : req0_lock;
            end
         end else begin
            baud_q <= baud_wrap ? 14'd0 : baud_q + 14'd1;
            if (baud_wrap) begin
               case (state_q)
                  START: begin
                     tx_q    <= shift_q[0];
                     shift_q <= {1'b0, shift_q[7:1]};
                  end
                  DATA: begin
                     bit_q <= bit_q + 3'd1;
                     if (bit_q == 3'd7) begin
                        tx_q <= 1'b1;
                     end else begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                     end
                  end
                  default: tx_q <= 1'b1;
               endcase
            end
         end
      end
   end

   assign req0_ready = pick0;
   assign req1_ready = pick1;
   assign tx         = tx_q;
   assign busy       = (state_q != IDLE);
   assign grant      = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BAUD_PER, default 10416, clk cycles per bit (9600 bd at 100 MHz); legal range 2..16383.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a byte to send.
REQ-005 req0_data  input  8  requester 0 byte; sampled only on accept.
REQ-006 req0_lock  input  1  requester 0 requests to keep ownership after the current byte.
REQ-007 req0_ready  output  1  one-cycle accept pulse for requester 0.
REQ-008 req1_valid, req1_data[7:0], req1_lock, req1_ready: same as REQ-004..007 for requester 1.
REQ-009 tx  output  1  serial line, 8N1, idle high.
REQ-010 busy  output  1  high while a frame is in progress, i.e. in any state other than IDLE.
REQ-011 grant  output  2  one-hot current or last owner; 2'b00 only after reset until the first accept.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-013 In IDLE, the block SHALL select at most one requester per cycle, assert its readyN for exactly that cycle, latch its data, update grant, and move to START.
REQ-014 Arbitration: if both requesters are valid, grant SHALL go to the requester not granted last; with no history, requester 0 wins.
REQ-015 Lock: if the owner's lock was high at its last accept and is still high in IDLE, the other requester SHALL NOT be granted; with the owner's valid low, the block waits in IDLE with tx high.
REQ-016 When the owner's lock drops, normal arbitration SHALL resume in the same cycle.
REQ-017 Accept in cycle T: tx SHALL go low at T+1; start, each data bit (LSB first) and stop bit SHALL each last exactly BAUD_PER cycles.
REQ-018 The baud counter SHALL restart at 0 on entry to START and wrap at BAUD_PER-1; state or bit advances on the wrap.
REQ-019 The 3-bit bit index SHALL advance 0..7 in DATA; the wrap at index 7 SHALL move to STOP.
REQ-020 STOP wrap SHALL return to IDLE; the frame occupies cycles T+1..T+10*BAUD_PER; the earliest next accept is T+1+10*BAUD_PER, which gives one idle-high cycle between frames.
REQ-021 readyN SHALL never assert outside IDLE, and never for both requesters in the same cycle.
REQ-022 Changes on reqN_data after accept SHALL NOT affect the frame in flight.
REQ-023 tx SHALL be driven from a register, with no combinational path from inputs.

Reset
REQ-024 With rst high at a clock edge: state=IDLE, tx=1, busy=0, req0_ready=req1_ready=0, grant=2'b00, baud counter=0, bit index=0, shift register=0, lock history cleared.
REQ-025 rst mid-frame SHALL abort the frame; tx SHALL be 1 from the next cycle; the aborted byte is not retransmitted.
REQ-026 The first accept SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-027 Macro UART_TX_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins simultaneous requests, replacing REQ-014; lock behaviour per REQ-015 still applies.
REQ-028 When the macro is undefined, round-robin per REQ-014 applies.

Verification
REQ-029 BAUD_PER=4; req0 sends 8'hA5 -> tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; req0_ready pulses once.
REQ-030 Both requesters valid continuously, bytes 8'h11 and 8'h22, no lock -> frames alternate 11,22,11,22 with a 1-cycle idle gap between frames (under the fixed-priority macro: 11,11,11).
REQ-031 req1_lock high, req1 sends 3 bytes with a 5-cycle valid gap before the 3rd, req0 valid throughout -> all 3 req1 frames go out before any req0 frame; tx stays high during the gap.
REQ-032 rst pulsed mid-DATA -> next cycle tx=1, busy=0, grant=00; a new request afterwards gets a correct full frame.
REQ-033 reqN_data changed the cycle after accept -> the transmitted byte equals the accepted value.
